// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: channel count,
// select width, packet counter width and FSM state encodings.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUTE = 1'b1;

    // One-hot channel mask for a select value.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register (valid/data/last) for a single demux channel.
// A load always wins over a drain so drain-and-refill keeps the slot full.
module out_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    // Data/last only change on load so they hold while the slot is empty.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/stream_demux_1to4.sv
// Packet-aware 1-to-4 stream demultiplexer: the channel is chosen on a
// packet's first beat and locked until the last beat is accepted.
module stream_demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic                     busy,
    output logic [CNT_W-1:0]         pkt_cnt
);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [SEL_W-1:0]  tgt_sel;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] slot_valid;

    // Target is the live select in IDLE and the locked select inside a packet.
    always_comb begin
        tgt_sel  = (state_q == ST_ROUTE) ? cur_sel_q : in_sel;
        in_ready = !rst && (!slot_valid[tgt_sel] || out_ready[tgt_sel]);
        accept   = in_valid && in_ready;
        load     = accept ? sel_onehot(tgt_sel) : '0;
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        pkt_cnt_d = pkt_cnt_q;
        if (accept) begin
            if (in_last) begin
                state_d   = ST_IDLE;
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end else if (state_q == ST_IDLE) begin
                state_d   = ST_ROUTE;
                cur_sel_d = in_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[ch]),
            .drain_i (out_ready[ch]),
            .data_i  (in_data),
            .last_i  (in_last),
            .valid_o (slot_valid[ch]),
            .data_o  (out_data[ch*DATA_W +: DATA_W]),
            .last_o  (out_last[ch])
        );
    end

    assign out_valid = slot_valid;
    assign busy      = (state_q == ST_ROUTE);
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Scoreboard bench for stream_demux_1to4: the driver queues expected beats per
// channel on acceptance, a negedge monitor pops them on each output handshake.
module tb_stream_demux_1to4;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NCH    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        in_sel = '0;
    logic              in_last = 1'b0;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready = '1;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH-1:0]    out_last;
    logic              busy;
    logic [7:0]        pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W:0] exp_q [NCH][$];
    logic            m_route = 1'b0;
    logic [1:0]      m_sel = '0;
    logic [7:0]      m_pkt = '0;

    stream_demux_1to4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference packet model: decides the channel and queues the expected beat.
    function automatic void model_accept(logic [1:0] sel, logic [DATA_W-1:0] data, logic last);
        logic [1:0] tgt;
        tgt = m_route ? m_sel : sel;
        exp_q[tgt].push_back({last, data});
        if (last) begin
            m_route = 1'b0;
            m_pkt   = m_pkt + 8'd1;
        end else if (!m_route) begin
            m_route = 1'b1;
            m_sel   = sel;
        end
    endfunction

    // Output monitor: a handshake seen before the edge completes at that edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (out_valid[ch] && out_ready[ch]) begin
                    if (exp_q[ch].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ch%0d_unexpected: got %0h expected none", ch,
                                 {out_last[ch], out_data[ch*DATA_W +: DATA_W]});
                    end else begin
                        check($sformatf("ch%0d_beat", ch),
                              32'({out_last[ch], out_data[ch*DATA_W +: DATA_W]}),
                              32'(exp_q[ch].pop_front()));
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [1:0] sel, input logic [DATA_W-1:0] data,
                             input logic last, output int waits);
        bit done = 0;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        waits    = 0;
        while (!done && waits < 50) begin
            @(negedge clk);
            waits++;
            if (in_ready) begin
                model_accept(sel, data, last);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int ch = 0; ch < NCH; ch++) exp_q[ch].delete();
        m_route = 1'b0;
        m_sel   = '0;
        m_pkt   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [7:0] pkt_start;

        // Reset state
        in_valid = 1'b1;
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);

        // Single beat to channel 2
        send_beat(2'd2, 8'hA5, 1'b1, w);
        check("single_out_valid", 32'(out_valid), 32'h4);
        check("single_data2", 32'(out_data[23:16]), 32'hA5);
        check("single_last2", 32'(out_last[2]), 32'd1);
        check("single_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        idle(1);
        check("hold_valid", 32'(out_valid), 32'h0);
        check("hold_data2", 32'(out_data[23:16]), 32'hA5);

        // Channel lock: select changes after the first beat are ignored
        send_beat(2'd1, 8'h11, 1'b0, w);
        check("lock_busy1", 32'(busy), 32'd1);
        send_beat(2'd3, 8'h22, 1'b0, w);
        check("lock_busy2", 32'(busy), 32'd1);
        check("lock_tput2", 32'(w), 32'd1);
        send_beat(2'd3, 8'h33, 1'b1, w);
        check("lock_busy3", 32'(busy), 32'd0);
        check("lock_pkt_cnt", 32'(pkt_cnt), 32'd2);
        idle(2);

        // Backpressure on channel 0, then drain and refill in one cycle
        out_ready = 4'b1110;
        send_beat(2'd0, 8'hB1, 1'b1, w);
        in_sel = 2'd0; in_data = 8'hB2; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 4'b1111;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid0", 32'(out_valid[0]), 32'd1);
        if (in_ready) model_accept(2'd0, 8'hB2, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_refilled", 32'(out_valid[0]), 32'd1);
        check("bp_data0", 32'(out_data[7:0]), 32'hB2);
        idle(2);

        // Isolation: full channel 3 must not stall channel 0
        out_ready = 4'b0111;
        send_beat(2'd3, 8'h77, 1'b1, w);
        send_beat(2'd0, 8'h01, 1'b0, w);
        check("iso_tput1", 32'(w), 32'd1);
        send_beat(2'd0, 8'h02, 1'b0, w);
        check("iso_tput2", 32'(w), 32'd1);
        send_beat(2'd0, 8'h03, 1'b1, w);
        check("iso_tput3", 32'(w), 32'd1);
        check("iso_valid3", 32'(out_valid[3]), 32'd1);
        check("iso_data3", 32'(out_data[31:24]), 32'h77);
        check("iso_last3", 32'(out_last[3]), 32'd1);
        out_ready = 4'b1111;
        idle(2);

        // Packet counter wrap
        pkt_start = m_pkt;
        for (int i = 0; i < 256; i++) begin
            send_beat(2'(i), 8'(i), 1'b1, w);
        end
        check("wrap_pkt_cnt", 32'(pkt_cnt), 32'(pkt_start));
        idle(2);

        // Reset in the middle of a 4-beat packet
        send_beat(2'd1, 8'hC1, 1'b0, w);
        send_beat(2'd1, 8'hC2, 1'b0, w);
        check("mid_busy_before", 32'(busy), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        send_beat(2'd2, 8'h5C, 1'b1, w);
        check("mid_new_valid", 32'(out_valid), 32'h4);
        check("mid_new_data2", 32'(out_data[23:16]), 32'h5C);
        check("mid_new_pkt_cnt", 32'(pkt_cnt), 32'd1);
        idle(4);

        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("drain_ch%0d", ch), 32'(exp_q[ch].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to4.md
STREAM_DEMUX_1TO4 -- requirements
Module: stream_demux_1to4

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data beat.
REQ-002 Parameter: NUM_CH, fixed 4, number of output channels; not overridable.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_data  input  DATA_W  upstream beat payload.
REQ-008 in_sel  input  2  destination channel; sampled only on a packet's first beat.
REQ-009 in_last  input  1  final beat of the packet.
REQ-010 out_valid  output  4  per-channel beat valid, bit i = channel i.
REQ-011 out_ready  input  4  per-channel downstream ready.
REQ-012 out_data  output  4*DATA_W  channel i payload in bits [i*DATA_W +: DATA_W].
REQ-013 out_last  output  4  per-channel last-beat flag.
REQ-014 busy  output  1  high while a multi-beat packet is open (state ROUTE).
REQ-015 pkt_cnt  output  8  count of completed packets accepted, all channels.

Function
REQ-016 Transfer occurs on any port only when its valid and ready are both high at the clock edge.
REQ-017 FSM states: IDLE (no open packet), ROUTE (packet open, channel locked).
REQ-018 IDLE -> ROUTE on an accepted beat with in_last=0, locking cur_sel <= in_sel.
REQ-019 ROUTE -> IDLE on an accepted beat with in_last=1; an accepted single-beat packet (in_last=1 in IDLE) leaves state IDLE.
REQ-020 Target channel: in_sel in IDLE, cur_sel in ROUTE; in_sel changes during ROUTE are ignored.
REQ-021 Each channel holds a one-entry output slot (valid, data, last).
REQ-022 in_ready = target slot empty OR out_ready of target channel high (combinational pass-through; drain and refill in same cycle).
REQ-023 Latency: an accepted beat is presented on its channel's out_valid/out_data/out_last on the next cycle.
REQ-024 Throughput: one beat per cycle sustained when target out_ready is held high.
REQ-025 A slot clears when drained and not refilled in the same cycle; non-target slots are unaffected by input traffic.
REQ-026 out_data/out_last hold their last value when out_valid is low.
REQ-027 A full non-target channel never stalls input to another channel.
REQ-028 pkt_cnt increments by 1 on each accepted beat with in_last=1; wraps 255 -> 0.
REQ-029 in_valid low in ROUTE keeps ROUTE indefinitely; no timeout.

Reset
REQ-030 On rst: state IDLE, cur_sel 0, all out_valid 0, out_data 0, out_last 0, pkt_cnt 0, busy 0.
REQ-031 in_ready is 0 during the cycle rst is high.
REQ-032 Reset mid-packet discards slot contents and open-packet state; first beat after reset is treated as a new packet.

Structure
REQ-033 Shared package demux_pkg holds NUM_CH, state encodings ST_IDLE/ST_ROUTE, and SEL_W=2.
REQ-034 Sub-module out_slot (one-entry valid/data/last register with load/drain) is instantiated once per channel.

Verification
REQ-035 Single beat: reset, in_sel=2, in_data=0xA5, in_last=1, all out_ready=1 -> next cycle out_valid=4'b0100, channel 2 data 0xA5, out_last[2]=1; pkt_cnt=1; busy stays 0.
REQ-036 Lock: 3-beat packet 0x11,0x22,0x33 with in_sel=1 on beat 1, in_sel=3 on beats 2-3 -> all three beats on channel 1 in order, busy high from after beat 1 through beat 3, out_last[1] only with 0x33.
REQ-037 Backpressure: out_ready[0]=0, send 2 beats to channel 0 -> first accepted, in_ready=0 thereafter; raise out_ready[0] -> second beat accepted in the same cycle the first drains.
REQ-038 Isolation: channel 3 slot full with out_ready[3]=0, packet to channel 0 -> accepted at 1 beat/cycle, channel 3 slot unchanged.
REQ-039 Wrap: 256 single-beat packets -> pkt_cnt returns to 0.
REQ-040 Reset mid-packet: assert rst after beat 2 of 4 -> all out_valid 0, busy 0, next beat with in_sel=2 routes to channel 2.
